serial_bit_tx: RTL and testbench

Parallel-to-serial bit source that feeds the team's bit-serial sequence detectors, such as the Moore "101" detector, through their single-bit `in` input. It accepts WIDTH-bit words through a valid/ready handshake and buffers one word. It emits the words MSB-first, one bit per enabled clock, with a bit-valid qualifier. A word already buffered follows the current word with no idle cycle, so detector streams can be built from consecutive words.

---
 rtl/serial_bit_tx.sv | 135 +++++++++++++
 tb/tb_serial_bit_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_tx.sv
// serial_bit_tx: parallel-to-serial bit source for the bit-serial sequence
// detectors. Buffers one WIDTH-bit word behind a valid/ready handshake and
// emits words MSB-first, one bit per tick, with no gap between buffered words.
// Optional feature macro: SERIAL_TX_PARITY_EN appends an even-parity bit
// (XOR of the data bits) after the LSB of every word.
module serial_bit_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             tick,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 2);
`ifdef SERIAL_TX_PARITY_EN
    localparam int LAST = WIDTH;
`else
    localparam int LAST = WIDTH - 1;
`endif
    localparam logic [CW-1:0] CNT_LAST = CW'(LAST);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bit_q, bit_d;
    logic             fill;
    logic             load;
    logic             accept;

`ifdef SERIAL_TX_PARITY_EN
    logic par_q, par_d;
    // Parity is shifted in at the LSB, so after WIDTH shifts it sits at the MSB.
    assign fill = par_q;
`else
    assign fill = 1'b0;
`endif

    // Next-state: handshake into hold, hold-to-shift transfer, bit stepping.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
`ifdef SERIAL_TX_PARITY_EN
        par_d       = par_q;
`endif
        load        = 1'b0;
        accept      = data_valid & ~hold_full_q;

        case (state_q)
            IDLE: begin
                // Buffered word starts immediately; does not wait for tick.
                if (hold_full_q) load = 1'b1;
            end
            SHIFT: begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        if (hold_full_q) load = 1'b1;
                        else             state_d = IDLE;
                    end else begin
                        sh_d  = {sh_q[WIDTH-2:0], fill};
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            sh_d        = hold_q;
            cnt_d       = '0;
            state_d     = SHIFT;
            hold_full_d = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_d       = ^hold_q;
`endif
        end

        // Accept and drain never coincide: accept needs the buffer empty.
        if (accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end

        // Output bit follows the shifter MSB while shifting, else holds.
        bit_d = (state_d == SHIFT) ? sh_d[WIDTH-1] : bit_q;
    end

    // State registers; reset discards any partially sent word.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sh_q        <= '0;
            cnt_q       <= '0;
            bit_q       <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    // Outputs decoded from registered state only (data_ready from the flag).
    always_comb begin
        data_ready  = ~hold_full_q;
        bit_out     = bit_q;
        bit_valid   = (state_q == SHIFT);
        frame_start = (state_q == SHIFT) && (cnt_q == '0);
        busy        = (state_q == SHIFT) || hold_full_q;
    end

endmodule

// File: tb/tb_serial_bit_tx.sv
// Bench for serial_bit_tx (WIDTH=8): a queue-based bit-stream model checked
// against the DUT every cycle, plus literal expectations per directed test.
module tb_serial_bit_tx;

`ifdef SERIAL_TX_PARITY_EN
    localparam int NB = 9;
    localparam int E_A5 = 'h14A, E_B2B = 'h29478, E_F0 = 'h1E0,
                   E_A4 = 'h149, E_81 = 'h102, E_07 = 'h00F;
`else
    localparam int NB = 8;
    localparam int E_A5 = 'hA5, E_B2B = 'hA53C, E_F0 = 'hF0,
                   E_A4 = 'hA4, E_81 = 'h81, E_07 = 'h07;
`endif

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       tick = 1'b1;
    logic [7:0] data_in = '0;
    logic       data_valid = 1'b0;
    logic       data_ready, bit_out, bit_valid, frame_start, busy;

    serial_bit_tx #(.WIDTH(8)) dut (
        .clk(clk), .clr_n(clr_n), .tick(tick), .data_in(data_in),
        .data_valid(data_valid), .data_ready(data_ready), .bit_out(bit_out),
        .bit_valid(bit_valid), .frame_start(frame_start), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- model: the stream of bits still to appear ----------------
    logic       mq[$];
    logic       m_full = 1'b0;
    logic [7:0] m_hold = '0;
    logic       m_last = 1'b0;
    int         acc_cyc[$];
    int         cyc_n = 0;

    task automatic m_load();
        mq.delete();
        for (int i = 7; i >= 0; i--) mq.push_back(m_hold[i]);
`ifdef SERIAL_TX_PARITY_EN
        mq.push_back(^m_hold);
`endif
        m_full = 1'b0;
    endtask

    initial forever begin
        logic pre_full, acc;
        @(posedge clk or negedge clr_n);
        if (!clr_n) begin
            mq.delete();
            m_full = 1'b0;
            m_last = 1'b0;
        end else begin
            cyc_n++;
            pre_full = m_full;
            acc = data_valid && !pre_full;
            if (mq.size() > 0) begin
                if (tick) begin
                    void'(mq.pop_front());
                    if (mq.size() == 0 && pre_full) m_load();
                end
            end else if (pre_full) begin
                m_load();
            end
            if (acc) begin
                m_hold = data_in;
                m_full = 1'b1;
                acc_cyc.push_back(cyc_n);
            end
            if (mq.size() > 0) m_last = mq[0];
        end
    end

    // ---------------- compare + capture on the falling edge ----------------
    logic [31:0] gpk, mpk;
    logic [2:0]  win;
    int vcnt, fcnt, det, run, maxrun;

    initial forever begin
        @(negedge clk);
        chk("bit_valid", int'(bit_valid), int'(mq.size() > 0));
        chk("bit_out", int'(bit_out), int'(m_last));
        chk("frame_start", int'(frame_start), int'(mq.size() == NB));
        chk("data_ready", int'(data_ready), int'(!m_full));
        chk("busy", int'(busy), int'(mq.size() > 0 || m_full));
        if (mq.size() > 0 && tick) mpk = {mpk[30:0], mq[0]};
        if (bit_valid && tick) begin
            gpk = {gpk[30:0], bit_out};
            win = {win[1:0], bit_out};
            if (win == 3'b101) det++;
        end
        if (bit_valid) begin
            vcnt++; run++;
            if (run > maxrun) maxrun = run;
        end else run = 0;
        if (frame_start) fcnt++;
    end

    // ---------------- drive ----------------
    logic pace = 1'b0;
    int   pcnt = 0;

    task automatic cyc();
        @(posedge clk); #1;
        if (pace) begin
            pcnt++;
            tick = (pcnt >= 4) && (pcnt % 3 == 1);
        end
    endtask

    task automatic send(input logic [7:0] w);
        int n0;
        n0 = acc_cyc.size();
        data_in = w;
        data_valid = 1'b1;
        for (int k = 0; k < 200 && acc_cyc.size() == n0; k++) cyc();
        if (acc_cyc.size() == n0) chk("accept_timeout", 1, 0);
        data_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 400 && (mq.size() > 0 || m_full); k++) cyc();
        if (mq.size() > 0 || m_full) chk("drain_timeout", 1, 0);
        cyc();
    endtask

    task automatic clr_log();
        gpk = '0; mpk = '0; win = '0;
        vcnt = 0; fcnt = 0; det = 0; run = 0; maxrun = 0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_bit_out"}, int'(bit_out), 0);
        chk({tag, "_bit_valid"}, int'(bit_valid), 0);
        chk({tag, "_frame_start"}, int'(frame_start), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_data_ready"}, int'(data_ready), 1);
    endtask

    initial begin
        clr_log();
        #1;
        chk_reset_outs("rst0");
        cyc(); cyc();
        clr_n = 1'b1;
        cyc();

        // single word, latency and bit order
        clr_log();
        send(8'hA5);
        chk("lat_busy", int'(busy), 1);
        chk("lat_valid", int'(bit_valid), 0);
        cyc();
        chk("lat_msb_valid", int'(bit_valid), 1);
        chk("lat_msb", int'(bit_out), 1);
        chk("lat_fs", int'(frame_start), 1);
        drain();
        chk("a5_bits", int'(gpk), E_A5);
        chk("a5_model", int'(mpk), E_A5);
        chk("a5_vcnt", vcnt, NB);
        chk("a5_fcnt", fcnt, 1);
        chk("a5_det", det, 2);
        chk("a5_idle", int'(bit_valid), 0);

        // back-to-back words, no gap
        clr_log();
        send(8'hA5);
        send(8'h3C);
        chk("b2b_acc_gap", acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2], 2);
        drain();
        chk("b2b_bits", int'(gpk), E_B2B);
        chk("b2b_model", int'(mpk), E_B2B);
        chk("b2b_run", maxrun, 2 * NB);
        chk("b2b_fcnt", fcnt, 2);

        // paced: tick every third cycle, each bit held 3 cycles
        clr_log();
        pace = 1'b1; pcnt = 0; tick = 1'b0;
        send(8'hF0);
        drain();
        pace = 1'b0; tick = 1'b1;
        chk("paced_bits", int'(gpk), E_F0);
        chk("paced_vcnt", vcnt, 3 * NB);
        chk("paced_fs_cycles", fcnt, 3);

        // detector chain: 1,0,1,0,0,1,0,0 contains "101" once (bits 0-2)
        clr_log();
        send(8'b1010_0100);
        drain();
        chk("det_bits", int'(gpk), E_A4);
        chk("det_count", det, 1);

        // reset mid-word with a second word buffered
        clr_log();
        send(8'hA5);
        send(8'h3C);
        cyc(); cyc();
        chk("mid_bits_sent", int'(gpk), 'b101);
        chk("mid_hold_full", int'(data_ready), 0);
        clr_n = 1'b0;
        #1;
        chk_reset_outs("rst_mid");
        cyc(); cyc();
        chk_reset_outs("rst_hold");
        clr_n = 1'b1;
        cyc(); cyc();
        chk("post_rst_idle", int'(bit_valid), 0);
        clr_log();
        send(8'h81);
        drain();
        chk("post_rst_bits", int'(gpk), E_81);
        chk("post_rst_fcnt", fcnt, 1);

        // parity-sensitive word (odd number of ones)
        clr_log();
        send(8'h07);
        drain();
        chk("w07_bits", int'(gpk), E_07);
        chk("w07_vcnt", vcnt, NB);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
